// File: rtl/pma_tx_scheduler.sv
// Slot scheduler in front of the PMA TX serializer: buffers PCS words in a small
// FIFO and launches one word (data, IDLE or SKP) every DATA_WIDTH bit-clock cycles.
module pma_tx_scheduler #(
  parameter int unsigned           DATA_WIDTH   = 10,
  parameter int unsigned           FIFO_DEPTH   = 4,
  parameter int unsigned           SKP_INTERVAL = 16,
  parameter int unsigned           SKP_LEN      = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_SYMBOL  = 10'h283,
  parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL   = 10'h2A3
) (
  input  logic                          Bit_Rate_Clk,
  input  logic                          Rst_n,
  input  logic                          Enable,
  input  logic [DATA_WIDTH-1:0]         Word_in,
  input  logic                          Word_Valid,
  output logic                          Word_Ready,
  output logic [DATA_WIDTH-1:0]         Ser_Data,
  output logic                          Ser_Data_En,
  output logic                          Word_Strobe,
  output logic                          Skp_Active,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = PW + 1;
  localparam int unsigned IW = (SKP_INTERVAL > 0) ? $clog2(SKP_INTERVAL + 1) : 1;
  localparam int unsigned RW = $clog2(SKP_LEN) + 1;

  localparam logic [CW-1:0] LAST_CNT   = CW'(DATA_WIDTH - 1);
  localparam logic [NW-1:0] DEPTH_C    = NW'(FIFO_DEPTH);
  localparam logic [IW-1:0] INT_MAX    = IW'(SKP_INTERVAL);
  localparam logic [RW-1:0] BURST_REST = RW'(SKP_LEN - 1);
  localparam bit            SKP_EN     = (SKP_INTERVAL != 0);

  typedef enum logic {ST_OFF, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         int_q, int_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  en_q, en_d;
  logic                  strobe_q, strobe_d;
  logic                  skp_q, skp_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]         count_q, count_d;
  logic                  push, pop;
  logic                  boundary, launch;

  assign Word_Ready  = (count_q < DEPTH_C);
  assign push        = Word_Valid && Word_Ready;
  assign Ser_Data    = data_q;
  assign Ser_Data_En = en_q;
  assign Word_Strobe = strobe_q;
  assign Skp_Active  = skp_q;
  assign Fifo_Count  = count_q;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    int_d    = int_q;
    rem_d    = rem_q;
    data_d   = data_q;
    en_d     = en_q;
    skp_d    = skp_q;
    strobe_d = 1'b0;
    pop      = 1'b0;
    boundary = (state_q == ST_OFF) ? Enable : (cnt_q == LAST_CNT);
    // An unfinished SKP burst keeps the link running even after Enable drops.
    launch   = boundary && (Enable || (rem_q != '0));

    if (launch) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      en_d     = 1'b1;
      strobe_d = 1'b1;
      if (rem_q != '0) begin
        rem_d  = rem_q - RW'(1);
        data_d = SKP_SYMBOL;
        skp_d  = 1'b1;
      end else if (SKP_EN && (int_q == INT_MAX)) begin
        rem_d  = BURST_REST;
        int_d  = '0;
        data_d = SKP_SYMBOL;
        skp_d  = 1'b1;
      end else begin
        skp_d = 1'b0;
        if (SKP_EN) int_d = int_q + IW'(1);
        if (count_q != '0) begin
          pop    = 1'b1;
          data_d = mem_q[rd_ptr_q];
        end else begin
          data_d = IDLE_SYMBOL;
        end
      end
    end else if (boundary) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      en_d    = 1'b0;
      data_d  = '0;
      skp_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Bit_Rate_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      int_q    <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      strobe_q <= 1'b0;
      skp_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      int_q    <= int_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      en_q     <= en_d;
      strobe_q <= strobe_d;
      skp_q    <= skp_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: storage array is not reset; emptiness is tracked by the reset pointers and count.
  always_ff @(posedge Bit_Rate_Clk) begin
    if (push) mem_q[wr_ptr_q] <= Word_in;
  end

endmodule

// File: tb/tb_pma_tx_scheduler.sv
// Bench for pma_tx_scheduler: slot-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pma_tx_scheduler;

  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int SKPI  = 4;
  localparam int SKPL  = 2;
  localparam logic [9:0] IDLE = 10'h283;
  localparam logic [9:0] SKP  = 10'h2A3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       word_valid = 1'b0;
  logic [9:0] word_in = '0;
  logic       word_ready, ser_data_en, word_strobe, skp_active;
  logic [9:0] ser_data;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pma_tx_scheduler #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .SKP_INTERVAL(SKPI),
    .SKP_LEN     (SKPL),
    .IDLE_SYMBOL (IDLE),
    .SKP_SYMBOL  (SKP)
  ) dut (
    .Bit_Rate_Clk(clk),
    .Rst_n       (rst_n),
    .Enable      (enable),
    .Word_in     (word_in),
    .Word_Valid  (word_valid),
    .Word_Ready  (word_ready),
    .Ser_Data    (ser_data),
    .Ser_Data_En (ser_data_en),
    .Word_Strobe (word_strobe),
    .Skp_Active  (skp_active),
    .Fifo_Count  (fifo_count)
  );

  // Reference model: slot schedule kept in absolute cycle numbers, FIFO as a queue.
  logic [9:0] m_fifo[$];
  bit         m_run    = 1'b0;
  bit         m_strobe = 1'b0;
  bit         m_skp    = 1'b0;
  logic [9:0] m_data   = '0;
  int         m_int    = 0;
  int         m_left   = 0;
  longint     m_cyc    = 0;
  longint     m_slot_end = 0;

  task automatic model_reset();
    m_fifo.delete();
    m_run    = 1'b0;
    m_strobe = 1'b0;
    m_skp    = 1'b0;
    m_data   = '0;
    m_int    = 0;
    m_left   = 0;
  endtask

  task automatic model_step();
    int n0;
    bit do_push, at_bnd;
    n0      = m_fifo.size();
    m_cyc   = m_cyc + 1;
    do_push = word_valid && (n0 < DEPTH);
    at_bnd  = m_run ? (m_cyc == m_slot_end) : enable;
    m_strobe = 1'b0;
    if (at_bnd && (enable || m_left > 0)) begin
      m_run      = 1'b1;
      m_strobe   = 1'b1;
      m_slot_end = m_cyc + DW;
      if (m_left > 0) begin
        m_left = m_left - 1;
        m_data = SKP;
        m_skp  = 1'b1;
      end else if (m_int >= SKPI) begin
        m_left = SKPL - 1;
        m_int  = 0;
        m_data = SKP;
        m_skp  = 1'b1;
      end else begin
        m_skp = 1'b0;
        m_int = m_int + 1;
        if (n0 > 0) m_data = m_fifo.pop_front();
        else        m_data = IDLE;
      end
    end else if (at_bnd) begin
      m_run  = 1'b0;
      m_data = '0;
      m_skp  = 1'b0;
    end
    if (do_push) m_fifo.push_back(word_in);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Cycle compare against the model on the inactive clock edge.
  initial begin
    logic [2:0] exp_cnt;
    bit         exp_rdy;
    forever begin
      @(negedge clk);
      exp_cnt = 3'(m_fifo.size());
      exp_rdy = (m_fifo.size() < DEPTH);
      checks++;
      if ({ser_data, ser_data_en, word_strobe, skp_active, fifo_count, word_ready} !==
          {m_data, m_run, m_strobe, m_skp, exp_cnt, exp_rdy}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got/exp data=%h/%h en=%b/%b stb=%b/%b skp=%b/%b cnt=%0d/%0d rdy=%b/%b",
                 $time, ser_data, m_data, ser_data_en, m_run, word_strobe, m_strobe,
                 skp_active, m_skp, fifo_count, exp_cnt, word_ready, exp_rdy);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    word_valid = 1'b0;
    rst_n      = 1'b0;
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [9:0] w);
    word_valid = 1'b1;
    word_in    = w;
    tick();
    word_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_data", 32'(ser_data), 32'h0);
    check("rst_en", 32'(ser_data_en), 32'h0);
    check("rst_ready", 32'(word_ready), 32'h1);

    // Empty FIFO: IDLE slots, strobe every DW cycles, SKP burst after 4 slots.
    enable = 1'b1;
    tick();
    check("idle_first_data", 32'(ser_data), 32'(IDLE));
    check("idle_first_en", 32'(ser_data_en), 32'h1);
    check("idle_first_stb", 32'(word_strobe), 32'h1);
    tick();
    check("idle_stb_low", 32'(word_strobe), 32'h0);
    ticks(9);
    check("idle_second_stb", 32'(word_strobe), 32'h1);
    check("idle_second_data", 32'(ser_data), 32'(IDLE));
    ticks(30);
    check("idle_skp1", 32'({skp_active, ser_data}), 32'({1'b1, SKP}));
    ticks(10);
    check("idle_skp2", 32'({skp_active, ser_data}), 32'({1'b1, SKP}));
    ticks(10);
    check("idle_after_skp", 32'({skp_active, ser_data}), 32'({1'b0, IDLE}));

    // Three buffered words launch in order, then IDLE, then SKP; Enable drop mid-burst.
    do_reset();
    push_word(10'h155);
    push_word(10'h0AA);
    push_word(10'h3C3);
    check("three_count", 32'(fifo_count), 32'd3);
    enable = 1'b1;
    tick();
    check("w0_data", 32'(ser_data), 32'h155);
    check("w0_count", 32'(fifo_count), 32'd2);
    ticks(10);
    check("w1_data", 32'(ser_data), 32'h0AA);
    check("w1_count", 32'(fifo_count), 32'd1);
    ticks(10);
    check("w2_data", 32'(ser_data), 32'h3C3);
    check("w2_count", 32'(fifo_count), 32'd0);
    ticks(10);
    check("w3_idle", 32'(ser_data), 32'(IDLE));
    ticks(10);
    check("burst_first", 32'(skp_active), 32'h1);
    ticks(3);
    enable = 1'b0;
    ticks(7);
    check("burst_second_skp", 32'({skp_active, ser_data}), 32'({1'b1, SKP}));
    check("burst_second_en", 32'(ser_data_en), 32'h1);
    ticks(9);
    check("burst_tail_en", 32'(ser_data_en), 32'h1);
    tick();
    check("stop_en", 32'(ser_data_en), 32'h0);
    check("stop_data", 32'(ser_data), 32'h0);

    // Full FIFO: overflow word rejected; push and pop on a boundary edge.
    do_reset();
    push_word(10'h101);
    push_word(10'h102);
    push_word(10'h103);
    push_word(10'h104);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(word_ready), 32'h0);
    word_valid = 1'b1;
    word_in    = 10'h1FF;
    tick();
    word_valid = 1'b0;
    check("overflow_count", 32'(fifo_count), 32'd4);
    enable = 1'b1;
    tick();
    check("full_launch", 32'(ser_data), 32'h101);
    check("full_pop_count", 32'(fifo_count), 32'd3);
    ticks(9);
    word_valid = 1'b1;
    word_in    = 10'h222;
    tick();
    word_valid = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'd3);
    check("pushpop_data", 32'(ser_data), 32'h102);
    ticks(50);
    check("late_word", 32'(ser_data), 32'h222);

    // Asynchronous reset mid-slot with two words buffered.
    do_reset();
    push_word(10'h011);
    push_word(10'h022);
    push_word(10'h033);
    enable = 1'b1;
    tick();
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    ticks(3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'({ser_data, ser_data_en, word_strobe, skp_active}), 32'h0);
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_ready", 32'(word_ready), 32'h1);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);
    check("post_rst_off", 32'(ser_data_en), 32'h0);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    enable = 1'b1;
    tick();
    check("reentry_stb", 32'({word_strobe, ser_data}), 32'({1'b1, IDLE}));

    // Randomized traffic, Enable toggling and rare async resets.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      word_valid = ($urandom_range(0, 99) < ((i < 2000) ? 8 : 25));
      word_in    = 10'($urandom);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ($urandom_range(0, 999) < 2) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
